rx_receiver: RTL and testbench

RX_RECEIVER -- requirements
Module: rx_receiver

---
 rtl/rx_receiver.sv | 148 ++++++++++++++
 tb/tb_rx_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_receiver.sv
// rtl/rx_receiver.sv - 8N1 serial receiver, oversampled by baudTick, with framing-error flag
// Synchronizes rx, centres on the start bit, then samples each bit once per OVERSAMPLE ticks.

module rx_receiver #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       baudTick,
   input  logic       rx,
   output logic [7:0] rx_out,
   output logic       rx_done,
   output logic       frame_error,
   output logic [1:0] static_state
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_n;
   logic            rx_meta;
   logic            rx_s;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_n;
   logic [2:0]      bit_idx;
   logic [2:0]      bit_idx_n;
   logic [7:0]      shift_reg;
   logic [7:0]      shift_n;
   logic [7:0]      rx_out_n;
   logic            rx_done_n;
   logic            frame_error_n;

   // Synchronizer resets to the idle line level so release never looks like a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         count       <= '0;
         bit_idx     <= 3'd0;
         shift_reg   <= 8'h00;
         rx_out      <= 8'h00;
         rx_done     <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state_q     <= state_n;
         count       <= count_n;
         bit_idx     <= bit_idx_n;
         shift_reg   <= shift_n;
         rx_out      <= rx_out_n;
         rx_done     <= rx_done_n;
         frame_error <= frame_error_n;
      end
   end

   always_comb begin
      state_n       = state_q;
      count_n       = count;
      bit_idx_n     = bit_idx;
      shift_n       = shift_reg;
      rx_out_n      = rx_out;
      rx_done_n     = 1'b0;
      frame_error_n = frame_error;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               count_n = '0;
            end
         end

         START: begin
            if (baudTick) begin
               if (count == HALF_LAST) begin
                  count_n = '0;
                  if (!rx_s) begin
                     state_n   = DATA;
                     bit_idx_n = 3'd0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  count_n = count + CW'(1);
               end
            end
         end

         DATA: begin
            if (baudTick) begin
               if (count == FULL_LAST) begin
                  count_n = '0;
                  shift_n = {rx_s, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state_n   = STOP;
                     bit_idx_n = 3'd0;
                  end else begin
                     bit_idx_n = bit_idx + 3'd1;
                  end
               end else begin
                  count_n = count + CW'(1);
               end
            end
         end

         STOP: begin
            if (baudTick) begin
               if (count == FULL_LAST) begin
                  count_n = '0;
                  state_n = IDLE;
                  // A low stop bit keeps the previous good byte visible.
                  if (rx_s) begin
                     rx_out_n      = shift_reg;
                     rx_done_n     = 1'b1;
                     frame_error_n = 1'b0;
                  end else begin
                     frame_error_n = 1'b1;
                  end
               end else begin
                  count_n = count + CW'(1);
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign static_state = state_q;

endmodule

// File: tb/tb_rx_receiver.sv
// tb/tb_rx_receiver.sv - directed self-checking bench for rx_receiver
// baudTick every 4 clocks with OVERSAMPLE=16, so one serial bit is 64 clocks.

module tb_rx_receiver;

   logic       clock;
   logic       reset;
   logic       baudTick;
   logic       rx;
   logic [7:0] rx_out;
   logic       rx_done;
   logic       frame_error;
   logic [1:0] static_state;

   int         errors;
   int         checks;
   int         done_count;
   logic [7:0] done_q[$];
   logic       tick_en;
   logic [1:0] div;

   localparam int BIT_CLKS = 64;

   rx_receiver #(.OVERSAMPLE(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .baudTick     (baudTick),
      .rx           (rx),
      .rx_out       (rx_out),
      .rx_done      (rx_done),
      .frame_error  (frame_error),
      .static_state (static_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      baudTick = 1'b0;
      div      = 2'd0;
      forever begin
         @(negedge clock);
         if (tick_en) begin
            div      = div + 2'd1;
            baudTick = (div == 2'd0);
         end else begin
            baudTick = 1'b0;
         end
      end
   end

   initial begin
      done_count = 0;
      forever begin
         @(posedge clock);
         #1;
         if (rx_done === 1'b1) begin
            done_count = done_count + 1;
            done_q.push_back(rx_out);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      rx = stop;
      wait_clks(stop_clks);
      rx = 1'b1;
   endtask

   task automatic clear_mon();
      done_count = 0;
      done_q.delete();
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      rx      = 1'b1;
      tick_en = 1'b1;
      wait_clks(3);
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL reset_static: got %0d expected 0", static_state); end
      checks++; if (rx_out !== 8'h00) begin errors++; $display("FAIL reset_rx_out: got %h expected 00", rx_out); end
      checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b expected 0", rx_done); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
      reset = 1'b1;
      wait_clks(20);
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL idle_after_reset: got %0d expected 0", static_state); end
   endtask

   task automatic test_valid();
      clear_mon();
      send_frame(8'h75, 1'b1, BIT_CLKS);
      wait_clks(20);
      checks++; if (done_count !== 1) begin errors++; $display("FAIL valid_done_count: got %0d expected 1", done_count); end
      checks++; if (done_q.size() < 1 || done_q[0] !== 8'h75) begin errors++; $display("FAIL valid_done_data: got size %0d expected 75 with pulse", done_q.size()); end
      checks++; if (rx_out !== 8'h75) begin errors++; $display("FAIL valid_rx_out: got %h expected 75", rx_out); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL valid_frame_error: got %b expected 0", frame_error); end
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL valid_static: got %0d expected 0", static_state); end
   endtask

   task automatic test_glitch();
      clear_mon();
      rx = 1'b0;
      wait_clks(10);
      checks++; if (static_state !== 2'd1) begin errors++; $display("FAIL glitch_start: got %0d expected 1", static_state); end
      wait_clks(10);
      rx = 1'b1;
      wait_clks(BIT_CLKS);
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL glitch_idle: got %0d expected 0", static_state); end
      checks++; if (done_count !== 0) begin errors++; $display("FAIL glitch_no_done: got %0d expected 0", done_count); end
      checks++; if (rx_out !== 8'h75) begin errors++; $display("FAIL glitch_rx_out: got %h expected 75", rx_out); end
   endtask

   task automatic test_frame_error();
      clear_mon();
      send_frame(8'hA5, 1'b0, 48);
      wait_clks(3 * BIT_CLKS);
      checks++; if (frame_error !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_error); end
      checks++; if (done_count !== 0) begin errors++; $display("FAIL ferr_no_done: got %0d expected 0", done_count); end
      checks++; if (rx_out !== 8'h75) begin errors++; $display("FAIL ferr_rx_out: got %h expected 75", rx_out); end
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL ferr_static: got %0d expected 0", static_state); end
      send_frame(8'h3C, 1'b1, BIT_CLKS);
      wait_clks(20);
      checks++; if (rx_out !== 8'h3C) begin errors++; $display("FAIL ferr_next_rx_out: got %h expected 3c", rx_out); end
      checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL ferr_next_clear: got %b expected 0", frame_error); end
      checks++; if (done_count !== 1) begin errors++; $display("FAIL ferr_next_done: got %0d expected 1", done_count); end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      send_frame(8'h00, 1'b1, BIT_CLKS);
      send_frame(8'hFF, 1'b1, BIT_CLKS);
      wait_clks(20);
      checks++; if (done_count !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_count); end
      checks++; if (done_q.size() < 2 || done_q[0] !== 8'h00 || done_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_data: got size %0d expected 00 then ff", done_q.size()); end
      checks++; if (rx_out !== 8'hFF) begin errors++; $display("FAIL b2b_rx_out: got %h expected ff", rx_out); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      clear_mon();
      d = 8'hC3;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      wait_clks(20);
      checks++; if (static_state !== 2'd2) begin errors++; $display("FAIL rmid_in_data: got %0d expected 2", static_state); end
      #2;
      reset = 1'b0;
      rx    = 1'b1;
      #1;
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL rmid_static: got %0d expected 0", static_state); end
      checks++; if (rx_out !== 8'h00) begin errors++; $display("FAIL rmid_rx_out: got %h expected 00", rx_out); end
      checks++; if (frame_error !== 1'b0 || rx_done !== 1'b0) begin errors++; $display("FAIL rmid_flags: got fe=%b done=%b expected 0 0", frame_error, rx_done); end
      wait_clks(4);
      reset = 1'b1;
      wait_clks(BIT_CLKS);
      checks++; if (static_state !== 2'd0 || done_count !== 0) begin errors++; $display("FAIL rmid_quiet: got state=%0d done=%0d expected 0 0", static_state, done_count); end
      send_frame(8'h5A, 1'b1, BIT_CLKS);
      wait_clks(20);
      checks++; if (rx_out !== 8'h5A) begin errors++; $display("FAIL rmid_next_rx_out: got %h expected 5a", rx_out); end
      checks++; if (done_count !== 1) begin errors++; $display("FAIL rmid_next_done: got %0d expected 1", done_count); end
   endtask

   task automatic test_baud_hold();
      clear_mon();
      tick_en = 1'b0;
      wait_clks(2);
      rx = 1'b0;
      wait_clks(10);
      checks++; if (static_state !== 2'd1) begin errors++; $display("FAIL hold_start: got %0d expected 1", static_state); end
      wait_clks(200);
      checks++; if (static_state !== 2'd1) begin errors++; $display("FAIL hold_stays: got %0d expected 1", static_state); end
      checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL hold_count: got %0d expected 0", dut.count); end
      rx      = 1'b1;
      tick_en = 1'b1;
      wait_clks(BIT_CLKS);
      checks++; if (static_state !== 2'd0) begin errors++; $display("FAIL hold_release: got %0d expected 0", static_state); end
      checks++; if (done_count !== 0) begin errors++; $display("FAIL hold_no_done: got %0d expected 0", done_count); end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      tick_en = 1'b0;
      reset   = 1'b0;
      rx      = 1'b1;
      test_reset();
      test_valid();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_reset_mid();
      test_baud_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
